mips_cycle_controller: RTL and testbench
========================================

# mips_cycle_controller

Multi-cycle control sequencer for the 32-bit MIPS core. It replaces fixed cycle counting with per-opcode state sequencing through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives the program-counter write strobe and next-PC select, the IR load, memory requests and register-file write. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- RETIRE_W, 32: width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from the IR; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in EXECUTE
- imem_ready  in  1  instruction memory done; IR data valid this cycle
- dmem_ready  in  1  data memory done
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5
- imem_req  out  1  fetch request
- ir_we  out  1  load IR
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (sw)
- alu_src  out  1  1 = immediate operand
- alu_op  out  2  00 add, 01 sub, 10 use funct
- reg_we  out  1  register file write
- mem_to_reg  out  1  writeback from memory data
- pc_we  out  1  PC update strobe
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- instret  out  RETIRE_W  retired-instruction count
- illegal  out  1  sticky; an unsupported opcode was decoded
- halted  out  1  high in HALT

## Operation
- Supported opcodes:
  - R-type 000000
  - addi 001000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - halt 111111
  - All others are illegal.
- op_q: register loaded from opcode in the DECODE cycle. It is the only opcode source for EXECUTE/MEMORY/WRITEBACK.
- State transitions and strobes:
  - FETCH: imem_req=1. Stay while !imem_ready. When imem_ready=1: ir_we=1, next state DECODE.
  - DECODE: one cycle, decision made on the live opcode.
    - j: pc_we=1, pc_src=2, retire, next FETCH.
    - halt: next HALT; no pc_we, no retire.
    - illegal: pc_we=1, pc_src=0, set illegal, no retire, next FETCH.
    - otherwise: next EXECUTE.
  - EXECUTE: one cycle.
    - alu_src=1 for addi/lw/sw.
    - alu_op=01 for beq, 10 for R-type, 00 otherwise.
    - beq: pc_we=1, pc_src = zero ? 1 : 0, retire, next FETCH.
    - lw/sw: next MEMORY.
    - R-type/addi: next WRITEBACK.
  - MEMORY: dmem_req=1, dmem_we=(op_q==sw). Stay while !dmem_ready. When ready:
    - sw: pc_we=1, pc_src=0, retire, next FETCH.
    - lw: next WRITEBACK.
  - WRITEBACK: reg_we=1, mem_to_reg=(op_q==lw), pc_we=1, pc_src=0, retire, next FETCH.
  - HALT: all strobes 0, halted=1. Exit only via reset.
- "Retire" means instret increments by 1 on that clock edge, wrapping modulo 2^RETIRE_W.
- All strobes are combinational from state, op_q/opcode and ready/zero. Outside the listed conditions they are 0, and pc_src=0.
- pc_we is asserted in exactly one cycle per non-halt instruction.
- imem_req and dmem_req are never asserted together.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, op_q=0, instret=0, illegal=0. halted=0.
  - Combinational outputs follow state FETCH: imem_req=1, everything else 0.
  - ir_we is forced 0 while rst_n is low.
- Reset asserted in any state aborts the instruction with no pc_we and no retire. The first cycle after deassertion is FETCH.
- Latency with zero wait states (imem_ready/dmem_ready high on first request cycle):
  - j: 2 cycles
  - beq: 3 cycles
  - R-type/addi/sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle. Requests stay asserted and stable until ready.
- A ready input arriving in a state that does not request it is ignored.
- The PC updates on the edge ending the pc_we cycle. The next FETCH presents the new PC.

## Test plan
- Reset, then lw with both readies tied 1 -> states 0,1,2,3,4 then 0. ir_we in cycle 1, dmem_req=1/dmem_we=0 in cycle 4, reg_we=mem_to_reg=pc_we=1 in cycle 5, instret=1.
- R-type with imem_ready low for 3 cycles -> FETCH held 4 cycles with imem_req=1, ir_we only in the 4th. alu_op=10 in EXECUTE. Total 7 cycles, pc_src=0.
- beq with zero=1, then beq with zero=0 -> pc_we in EXECUTE with pc_src=1, then pc_src=0. 3 cycles each, instret=2.
- j, then opcode 111110, then halt -> j: pc_src=2 in DECODE, instret=1. Illegal opcode: pc_we=1/pc_src=0, illegal=1, instret stays 1. Halt: halted=1, no strobes for 10 cycles.
- sw with dmem_ready low 2 cycles; rst_n pulsed low mid-wait on the next sw -> first sw retires in 6 cycles. During the reset pulse there is no pc_we, instret=0, and state returns to FETCH.
- instret with RETIRE_W=4: retire 16 j instructions -> instret wraps to 0.

Source files
------------

// File: rtl/mips_cycle_controller.sv
// Multi-cycle control sequencer for the 32-bit MIPS core: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives PC, IR, memory and register-file strobes.
module mips_cycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic [2:0]          state,
  output logic                imem_req,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                reg_we,
  output logic                mem_to_reg,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [RETIRE_W-1:0] instret,
  output logic                illegal,
  output logic                halted
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [RETIRE_W-1:0] RetireOne = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [RETIRE_W-1:0] instret_q;
  logic                illegal_q;
  logic                retire;
  logic                set_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      op_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (retire) begin
        instret_q <= instret_q + RetireOne;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // DECODE branches on the live opcode; later states use only the opcode captured in op_q.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SEQ;
    halted      = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = rst_n;
          state_d = DECODE;
        end
      end

      DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_J: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_HALT: begin
            state_d = HALT;
          end
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
            state_d = EXECUTE;
          end
          default: begin
            pc_we       = 1'b1;
            set_illegal = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end

      EXECUTE: begin
        alu_src = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
        if (op_q == OP_BEQ) begin
          alu_op = ALU_SUB;
        end else if (op_q == OP_RTYPE) begin
          alu_op = ALU_FUNCT;
        end
        case (op_q)
          OP_BEQ: begin
            pc_we   = 1'b1;
            pc_src  = zero ? PC_BRANCH : PC_SEQ;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_LW, OP_SW: begin
            state_d = MEMORY;
          end
          default: begin
            state_d = WRITEBACK;
          end
        endcase
      end

      MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end

      WRITEBACK: begin
        reg_we     = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_cycle_controller.sv
// Table-driven bench for mips_cycle_controller: one row per clock cycle, expected values
// queued at drive time and checked at the following falling edge.
module tb_mips_cycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ILL  = 6'b111110;
  localparam logic [5:0] OP_JUNK = 6'b010101;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_H = 3'd5;

  // Output vector layout: {imem_req, ir_we, dmem_req, dmem_we, alu_src, alu_op, reg_we, mem_to_reg, pc_we, pc_src, halted}
  localparam logic [12:0] O_NONE = 13'h0000;
  localparam logic [12:0] O_IREQ = 13'h1000;
  localparam logic [12:0] O_IRWE = 13'h0800;
  localparam logic [12:0] O_DREQ = 13'h0400;
  localparam logic [12:0] O_DWE  = 13'h0200;
  localparam logic [12:0] O_ASRC = 13'h0100;
  localparam logic [12:0] O_ASUB = 13'h0040;
  localparam logic [12:0] O_AFN  = 13'h0080;
  localparam logic [12:0] O_RWE  = 13'h0020;
  localparam logic [12:0] O_M2R  = 13'h0010;
  localparam logic [12:0] O_PWE  = 13'h0008;
  localparam logic [12:0] O_PCBR = 13'h0002;
  localparam logic [12:0] O_PCJ  = 13'h0004;
  localparam logic [12:0] O_HLT  = 13'h0001;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [12:0] out;
    logic        ret;
    logic        setIll;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;

  logic [2:0]  state;
  logic        imem_req, ir_we, dmem_req, dmem_we, alu_src, reg_we, mem_to_reg, pc_we, illegal, halted;
  logic [1:0]  alu_op, pc_src;
  logic [31:0] instret;

  logic [2:0]  w4State;
  logic        w4ImemReq, w4IrWe, w4DmemReq, w4DmemWe, w4AluSrc, w4RegWe, w4MemToReg, w4PcWe, w4Illegal, w4Halted;
  logic [1:0]  w4AluOp, w4PcSrc;
  logic [3:0]  w4Instret;

  logic [12:0] actOut;
  assign actOut = {imem_req, ir_we, dmem_req, dmem_we, alu_src, alu_op, reg_we, mem_to_reg, pc_we, pc_src, halted};

  row_t tbl[$];
  row_t expQ[$];
  logic [31:0] expRet = '0;
  logic expIll = 1'b0;
  int nAssert = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  mips_cycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .alu_src(alu_src), .alu_op(alu_op), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .pc_we(pc_we), .pc_src(pc_src), .instret(instret),
    .illegal(illegal), .halted(halted)
  );

  mips_cycle_controller #(.RETIRE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .state(w4State), .imem_req(w4ImemReq), .ir_we(w4IrWe), .dmem_req(w4DmemReq),
    .dmem_we(w4DmemWe), .alu_src(w4AluSrc), .alu_op(w4AluOp), .reg_we(w4RegWe),
    .mem_to_reg(w4MemToReg), .pc_we(w4PcWe), .pc_src(w4PcSrc), .instret(w4Instret),
    .illegal(w4Illegal), .halted(w4Halted)
  );

  function automatic row_t R(input logic rst, input logic [5:0] op, input logic z,
                             input logic ir, input logic dr, input logic [2:0] st,
                             input logic [12:0] out, input logic ret, input logic setIll);
    row_t r;
    r.rst = rst; r.op = op; r.z = z; r.ir = ir; r.dr = dr;
    r.st = st; r.out = out; r.ret = ret; r.setIll = setIll;
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL row%0d %s: got 0x%0h, expected 0x%0h", row, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input row_t r);
    rst_n      = r.rst;
    opcode     = r.op;
    zero       = r.z;
    imem_ready = r.ir;
    dmem_ready = r.dr;
    expQ.push_back(r);
  endtask

  task automatic checkOutput(input int row);
    row_t e;
    e = expQ.pop_front();
    if (!e.rst) begin
      expRet = '0;
      expIll = 1'b0;
    end
    check("state", row, {29'd0, state}, {29'd0, e.st});
    check("strobes", row, {19'd0, actOut}, {19'd0, e.out});
    check("instret", row, instret, expRet);
    check("illegal", row, {31'd0, illegal}, {31'd0, expIll});
    check("instret_w4", row, {28'd0, w4Instret}, {28'd0, expRet[3:0]});
    if (e.ret) expRet = expRet + 32'd1;
    if (e.setIll) expIll = 1'b1;
  endtask

  initial begin
    // reset held with imem_ready high: ir_we must stay low
    tbl.push_back(R(0, OP_LW, 0, 1, 1, ST_F, O_IREQ, 0, 0));
    tbl.push_back(R(0, OP_LW, 0, 1, 1, ST_F, O_IREQ, 0, 0));
    // lw, zero wait states, junk live opcode after DECODE
    tbl.push_back(R(1, OP_LW,   0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_LW,   0, 1, 1, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_JUNK, 0, 1, 1, ST_E, O_ASRC, 0, 0));
    tbl.push_back(R(1, OP_JUNK, 0, 1, 1, ST_M, O_DREQ, 0, 0));
    tbl.push_back(R(1, OP_JUNK, 0, 1, 1, ST_W, O_RWE | O_M2R | O_PWE, 1, 0));
    // R-type with three imem wait cycles
    tbl.push_back(R(1, OP_R, 0, 0, 1, ST_F, O_IREQ, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 0, 1, ST_F, O_IREQ, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 0, 1, ST_F, O_IREQ, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 1, 1, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 1, 1, ST_E, O_AFN, 0, 0));
    tbl.push_back(R(1, OP_R, 0, 1, 1, ST_W, O_RWE | O_PWE, 1, 0));
    // addi
    tbl.push_back(R(1, OP_ADDI, 0, 1, 0, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_ADDI, 0, 1, 0, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_ADDI, 0, 1, 0, ST_E, O_ASRC, 0, 0));
    tbl.push_back(R(1, OP_ADDI, 0, 1, 0, ST_W, O_RWE | O_PWE, 1, 0));
    // beq taken then not taken
    tbl.push_back(R(1, OP_BEQ, 1, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_BEQ, 1, 1, 1, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_BEQ, 1, 1, 1, ST_E, O_ASUB | O_PWE | O_PCBR, 1, 0));
    tbl.push_back(R(1, OP_BEQ, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_BEQ, 0, 1, 1, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_BEQ, 0, 1, 1, ST_E, O_ASUB | O_PWE, 1, 0));
    // j, then illegal opcode
    tbl.push_back(R(1, OP_J,   0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_J,   0, 1, 1, ST_D, O_PWE | O_PCJ, 1, 0));
    tbl.push_back(R(1, OP_ILL, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_ILL, 0, 1, 1, ST_D, O_PWE, 0, 1));
    // sw with two dmem wait cycles; imem_ready high in MEMORY is ignored
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_E, O_ASRC, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_M, O_DREQ | O_DWE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_M, O_DREQ | O_DWE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 1, ST_M, O_DREQ | O_DWE | O_PWE, 1, 0));
    // next sw aborted by reset mid-wait
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_D, O_NONE, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_E, O_ASRC, 0, 0));
    tbl.push_back(R(1, OP_SW, 0, 1, 0, ST_M, O_DREQ | O_DWE, 0, 0));
    tbl.push_back(R(0, OP_SW, 0, 1, 1, ST_F, O_IREQ, 0, 0));
    // sixteen jumps: narrow counter wraps back to zero
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(R(1, OP_J, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
      tbl.push_back(R(1, OP_J, 0, 1, 1, ST_D, O_PWE | O_PCJ, 1, 0));
    end
    // halt, then ten idle cycles with readies high
    tbl.push_back(R(1, OP_HALT, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_HALT, 0, 1, 1, ST_D, O_NONE, 0, 0));
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(R(1, (k % 2 == 0) ? OP_J : OP_SW, 1, 1, 1, ST_H, O_HLT, 0, 0));
    end
    // only reset leaves HALT
    tbl.push_back(R(0, OP_J, 0, 1, 1, ST_F, O_IREQ, 0, 0));
    tbl.push_back(R(1, OP_J, 0, 1, 1, ST_F, O_IREQ | O_IRWE, 0, 0));
    tbl.push_back(R(1, OP_J, 0, 1, 1, ST_D, O_PWE | O_PCJ, 1, 0));
    tbl.push_back(R(1, OP_R, 0, 0, 1, ST_F, O_IREQ, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput(i);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
